// File: rtl/ip_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ip_packet_tx
//  Purpose  : Builds an Ethernet II + IPv4 (no options) frame around a fixed
//             size payload, computes the IPv4 header checksum and streams the
//             frame byte-wise over AXI-Stream, zero-padded to the minimum size.
//             Multi-byte fields are MSB-first: the most significant byte of
//             every address / payload vector is the first one on the wire.
//  Revision : 1.0  initial release
// ============================================================================
module ip_packet_tx #(
    parameter int         USER_DATA_BYTES  = 10,
    parameter int         AXI_S_DATA_WIDTH = 8,
    parameter logic [7:0] IP_PROTOCOL      = 8'hFD,
    parameter logic [7:0] IP_TTL           = 8'h40,
    parameter int         MIN_FRAME_BYTES  = 60
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [31:0]                   ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                   ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0]                   DST_IP_ADDRESS,
    input  logic [47:0]                   DST_MAC_ADDRESS,
    input  logic [USER_DATA_BYTES*8-1:0]  DATA_FRAME,
    input  logic                          FRAME_VALID,
    output logic                          FRAME_READY,
    output logic [AXI_S_DATA_WIDTH-1:0]   MAC_DATA_IN,
    output logic                          MAC_DATA_VALID,
    input  logic                          MAC_DATA_READY,
    output logic                          MAC_DATA_LAST,
    output logic                          MAC_DATA_TUSER,
    output logic                          FRAME_SENT
);
    localparam int          PAY_W        = USER_DATA_BYTES * 8;
    localparam int          HDR_BYTES    = 34;                       // 14 Ethernet + 20 IPv4
    localparam int          PAY_END      = HDR_BYTES + USER_DATA_BYTES;
    localparam int          FRAME_LEN    = (PAY_END > MIN_FRAME_BYTES) ? PAY_END : MIN_FRAME_BYTES;
    localparam logic [15:0] LAST_IDX     = 16'(FRAME_LEN - 1);
    localparam logic [15:0] IDX_IP       = 16'd14;
    localparam logic [15:0] IDX_DATA     = 16'(HDR_BYTES);
    localparam logic [15:0] IDX_PAD      = 16'(PAY_END);
    localparam logic [15:0] IP_TOTAL_LEN = 16'(20 + USER_DATA_BYTES);
    localparam logic [15:0] CSUM_WORDS   = 16'd10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CSUM      = 3'd1,
        S_SEND_ETH  = 3'd2,
        S_SEND_IP   = 3'd3,
        S_SEND_DATA = 3'd4,
        S_SEND_PAD  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;      // checksum word index in CSUM, byte index in SEND_*
    logic [16:0]        acc_q, acc_d;
    logic [15:0]        csum_q, csum_d;
    logic [15:0]        id_q, id_d;
    logic               ready_q, ready_d;
    logic               sent_q, sent_d;
    logic [31:0]        src_ip_q, dst_ip_q;
    logic [47:0]        src_mac_q, dst_mac_q;
    logic [PAY_W-1:0]   data_q;

    logic               w_accept;
    logic               w_sending;
    logic [15:0]        w_cnt_inc;
    logic [15:0]        w_pay_idx;
    logic [159:0]       w_ip_sum_hdr;
    logic [271:0]       w_frame_hdr;
    logic [159:0]       w_word_sh;
    logic [271:0]       w_hdr_sh;
    logic [PAY_W-1:0]   w_pay_sh;
    logic [7:0]         w_byte;

    // Header as summed by the checksum engine: checksum field reads as zero
    assign w_ip_sum_hdr = {8'h45, 8'h00, IP_TOTAL_LEN, id_q, 16'h4000,
                           IP_TTL, IP_PROTOCOL, 16'h0000, src_ip_q, dst_ip_q};
    assign w_frame_hdr  = {dst_mac_q, src_mac_q, 16'h0800,
                           8'h45, 8'h00, IP_TOTAL_LEN, id_q, 16'h4000,
                           IP_TTL, IP_PROTOCOL, csum_q, src_ip_q, dst_ip_q};

    // Shift the wanted word/byte up to the top so the select index stays constant
    assign w_pay_idx = cnt_q - IDX_DATA;
    assign w_word_sh = w_ip_sum_hdr << {cnt_q, 4'b0000};
    assign w_hdr_sh  = w_frame_hdr << {cnt_q, 3'b000};
    assign w_pay_sh  = data_q << {w_pay_idx, 3'b000};

    assign w_accept  = (state_q == S_IDLE) && ready_q && FRAME_VALID;
    assign w_sending = (state_q == S_SEND_ETH) || (state_q == S_SEND_IP) ||
                       (state_q == S_SEND_DATA) || (state_q == S_SEND_PAD);
    assign w_cnt_inc = cnt_q + 16'd1;

    // Select the byte on the wire; zero outside the frame and in the pad region
    always_comb begin
        w_byte = 8'h00;
        case (state_q)
            S_SEND_ETH, S_SEND_IP: w_byte = w_hdr_sh[271:264];
            S_SEND_DATA:           w_byte = w_pay_sh[PAY_W-1 -: 8];
            default:               w_byte = 8'h00;
        endcase
    end

    assign FRAME_READY    = ready_q;
    assign FRAME_SENT     = sent_q;
    assign MAC_DATA_VALID = w_sending;
    assign MAC_DATA_IN    = AXI_S_DATA_WIDTH'(w_byte);
    assign MAC_DATA_LAST  = w_sending && (cnt_q == LAST_IDX);
    assign MAC_DATA_TUSER = 1'b0;

    // Next-state logic: accept, ten-word checksum walk, then byte streaming
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        csum_d  = csum_q;
        id_d    = id_q;
        sent_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_CSUM;
                    cnt_d   = 16'd0;
                    acc_d   = 17'd0;
                end
            end
            S_CSUM: begin
                if (cnt_q == CSUM_WORDS) begin
                    // Fold the last pending carry, then complement
                    csum_d  = ~(acc_q[15:0] + {15'd0, acc_q[16]});
                    cnt_d   = 16'd0;
                    state_d = S_SEND_ETH;
                end else begin
                    // End-around carry: previous add's carry re-enters this add
                    acc_d = {1'b0, acc_q[15:0]} + {1'b0, w_word_sh[159:144]} + {16'd0, acc_q[16]};
                    cnt_d = w_cnt_inc;
                end
            end
            S_SEND_ETH, S_SEND_IP, S_SEND_DATA, S_SEND_PAD: begin
                if (MAC_DATA_READY) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                        id_d    = id_q + 16'd1;
                        sent_d  = 1'b1;
                    end else begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == IDX_IP)   state_d = S_SEND_IP;
                        if (w_cnt_inc == IDX_DATA) state_d = S_SEND_DATA;
                        if (w_cnt_inc == IDX_PAD)  state_d = S_SEND_PAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Control and checksum state registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            acc_q   <= 17'd0;
            csum_q  <= 16'd0;
            id_q    <= 16'd0;
            ready_q <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            csum_q  <= csum_d;
            id_q    <= id_d;
            ready_q <= ready_d;
            sent_q  <= sent_d;
        end
    end

    // Snapshot of the request so callers may change inputs once accepted
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            src_ip_q  <= 32'd0;
            dst_ip_q  <= 32'd0;
            src_mac_q <= 48'd0;
            dst_mac_q <= 48'd0;
            data_q    <= '0;
        end else if (w_accept) begin
            src_ip_q  <= ACCELERATOR_IP_ADDRESS;
            dst_ip_q  <= DST_IP_ADDRESS;
            src_mac_q <= ACCELERATOR_MAC_ADDRESS;
            dst_mac_q <= DST_MAC_ADDRESS;
            data_q    <= DATA_FRAME;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_packet_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_packet_tx
//  Purpose  : Scoreboard bench for ip_packet_tx: 10-, 26- and 27-byte payload
//             instances, backpressure, back-to-back and mid-frame reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ip_packet_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  src_ip, dst_ip;
    logic [47:0]  src_mac, dst_mac;
    logic [79:0]  data10;
    logic [207:0] data26;
    logic [215:0] data27;
    logic         fv10, fv26, fv27;
    logic         ready10;
    logic         one;

    logic         fr10, fr26, fr27;
    logic [7:0]   dat10, dat26, dat27;
    logic         val10, val26, val27;
    logic         last10, last26, last27;
    logic         tu10, tu26, tu27;
    logic         sent10, sent26, sent27;

    logic [8:0]   q10[$], q26[$], q27[$];
    int           n_chk, n_err;
    int           cnt_sent10, cnt_sent26, cnt_sent27;
    int           beat10;
    logic         stall10_prev;
    logic [8:0]   stall10_val;
    logic [8:0]   mon_e;

    ip_packet_tx #(.USER_DATA_BYTES(10)) u10 (
        .ACLK(clk), .ARESET(rst),
        .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
        .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
        .DATA_FRAME(data10), .FRAME_VALID(fv10), .FRAME_READY(fr10),
        .MAC_DATA_IN(dat10), .MAC_DATA_VALID(val10), .MAC_DATA_READY(ready10),
        .MAC_DATA_LAST(last10), .MAC_DATA_TUSER(tu10), .FRAME_SENT(sent10));

    ip_packet_tx #(.USER_DATA_BYTES(26)) u26 (
        .ACLK(clk), .ARESET(rst),
        .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
        .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
        .DATA_FRAME(data26), .FRAME_VALID(fv26), .FRAME_READY(fr26),
        .MAC_DATA_IN(dat26), .MAC_DATA_VALID(val26), .MAC_DATA_READY(one),
        .MAC_DATA_LAST(last26), .MAC_DATA_TUSER(tu26), .FRAME_SENT(sent26));

    ip_packet_tx #(.USER_DATA_BYTES(27)) u27 (
        .ACLK(clk), .ARESET(rst),
        .ACCELERATOR_IP_ADDRESS(src_ip), .ACCELERATOR_MAC_ADDRESS(src_mac),
        .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
        .DATA_FRAME(data27), .FRAME_VALID(fv27), .FRAME_READY(fr27),
        .MAC_DATA_IN(dat27), .MAC_DATA_VALID(val27), .MAC_DATA_READY(one),
        .MAC_DATA_LAST(last27), .MAC_DATA_TUSER(tu27), .FRAME_SENT(sent27));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push the hand-computed frame (header constants, id and checksum given) to a queue
    task automatic push_frame(input int inst, input int udb, input logic [15:0] id,
                              input logic [15:0] csum, input logic [7:0] pay0);
        logic [7:0]  h[34];
        logic [15:0] tl;
        logic [7:0]  b;
        int          total;
        tl = 16'(20 + udb);
        h = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h00,
              8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
              8'h40, 8'hFD, csum[15:8], csum[7:0],
              8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h02, 8'h01};
        total = (34 + udb > 60) ? 34 + udb : 60;
        for (int k = 0; k < total; k++) begin
            if (k < 34)            b = h[k];
            else if (k < 34 + udb) b = pay0 + 8'(k - 34);
            else                   b = 8'h00;
            case (inst)
                0:       q10.push_back({(k == total - 1), b});
                1:       q26.push_back({(k == total - 1), b});
                default: q27.push_back({(k == total - 1), b});
            endcase
        end
    endtask

    task automatic set_payload(input logic [7:0] pay0);
        for (int k = 0; k < 10; k++) data10[79 - 8*k -: 8] = pay0 + 8'(k);
        for (int k = 0; k < 26; k++) data26[207 - 8*k -: 8] = pay0 + 8'(k);
        for (int k = 0; k < 27; k++) data27[215 - 8*k -: 8] = pay0 + 8'(k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sent10(input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (sent10) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_ready10(input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (fr10) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // Monitor: pop and compare each handshaken byte; check hold under stall
    always @(negedge clk) begin
        if (val10 && ready10) begin
            if (q10.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL u10 unexpected beat: got %0h expected none", {last10, dat10});
            end else begin
                mon_e = q10.pop_front();
                chk($sformatf("u10 beat %0d", beat10), {23'd0, last10, dat10}, {23'd0, mon_e});
            end
            beat10++;
        end
        if (stall10_prev && val10)
            chk("u10 stall hold", {23'd0, last10, dat10}, {23'd0, stall10_val});
        stall10_prev = val10 && !ready10;
        stall10_val  = {last10, dat10};

        if (val26) begin
            if (q26.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL u26 unexpected beat: got %0h expected none", {last26, dat26});
            end else begin
                mon_e = q26.pop_front();
                chk("u26 beat", {23'd0, last26, dat26}, {23'd0, mon_e});
            end
        end
        if (val27) begin
            if (q27.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL u27 unexpected beat: got %0h expected none", {last27, dat27});
            end else begin
                mon_e = q27.pop_front();
                chk("u27 beat", {23'd0, last27, dat27}, {23'd0, mon_e});
            end
        end
        if (sent10) cnt_sent10++;
        if (sent26) cnt_sent26++;
        if (sent27) cnt_sent27++;
    end

    // Directed stimulus
    initial begin
        int   lat;
        logic seen;
        n_chk = 0; n_err = 0; beat10 = 0;
        cnt_sent10 = 0; cnt_sent26 = 0; cnt_sent27 = 0;
        stall10_prev = 1'b0; stall10_val = 9'd0;
        one = 1'b1;
        rst = 1'b1; fv10 = 1'b0; fv26 = 1'b0; fv27 = 1'b0; ready10 = 1'b1;
        src_ip = 32'h01010202; src_mac = 48'h010203040506;
        dst_ip = 32'h01010201; dst_mac = 48'h112233445566;
        data10 = '0; data26 = '0; data27 = '0;
        set_payload(8'h01);
        repeat (3) step();

        chk("reset FRAME_READY", {31'd0, fr10}, 32'd0);
        chk("reset VALID", {31'd0, val10}, 32'd0);
        chk("reset LAST", {31'd0, last10}, 32'd0);
        chk("reset DATA", {24'd0, dat10}, 32'd0);
        chk("reset FRAME_SENT", {31'd0, sent10}, 32'd0);
        chk("reset TUSER", {31'd0, tu10}, 32'd0);
        rst = 1'b0;
        step();
        chk("ready after reset", {31'd0, fr10}, 32'd1);

        // Happy path on all three instances, inputs scrambled after accept
        push_frame(0, 10, 16'h0000, 16'h33DF, 8'h01);
        push_frame(1, 26, 16'h0000, 16'h33CF, 8'h01);
        push_frame(2, 27, 16'h0000, 16'h33CE, 8'h01);
        fv10 = 1'b1; fv26 = 1'b1; fv27 = 1'b1;
        step();
        fv10 = 1'b0; fv26 = 1'b0; fv27 = 1'b0;
        chk("ready drops on accept", {31'd0, fr10}, 32'd0);
        dst_mac = 48'hDEADBEEFCAFE; dst_ip = 32'hC0A80001;
        set_payload(8'hEE);
        lat = 1;
        while (!val10 && lat < 30) begin
            step();
            if (!val10) lat++;
        end
        chk("accept to first byte latency", lat, 32'd11);
        wait_sent10(200, "happy frame sent");
        dst_mac = 48'h112233445566; dst_ip = 32'h01010201;
        set_payload(8'h01);
        repeat (3) step();

        // Backpressure: alternate READY plus a 5-cycle hold mid-IP header
        push_frame(0, 10, 16'h0001, 16'h33DE, 8'h01);
        fv10 = 1'b1;
        step();
        fv10 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            ready10 = ((c >= 50 && c < 55) || (c % 2 == 1)) ? 1'b0 : 1'b1;
            step();
            if (sent10) seen = 1'b1;
        end
        ready10 = 1'b1;
        chk("backpressure frame sent", {31'd0, seen}, 32'd1);
        step();

        // Back-to-back with FRAME_VALID held; second frame takes new payload
        push_frame(0, 10, 16'h0002, 16'h33DD, 8'h01);
        fv10 = 1'b1;
        step();
        chk("b2b first accept", {31'd0, fr10}, 32'd0);
        set_payload(8'hA1);
        push_frame(0, 10, 16'h0003, 16'h33DC, 8'hA1);
        wait_ready10(200, "b2b ready returns");
        step();
        chk("b2b second accept", {31'd0, fr10}, 32'd0);
        fv10 = 1'b0;
        wait_sent10(200, "b2b second frame sent");
        set_payload(8'h01);
        step();

        // Reset while streaming the IP header
        push_frame(0, 10, 16'h0004, 16'h33DB, 8'h01);
        fv10 = 1'b1;
        step();
        fv10 = 1'b0;
        repeat (30) step();
        #1 rst = 1'b1;
        #1;
        chk("async reset VALID", {31'd0, val10}, 32'd0);
        chk("async reset LAST", {31'd0, last10}, 32'd0);
        chk("async reset FRAME_READY", {31'd0, fr10}, 32'd0);
        q10.delete();
        step();
        step();
        rst = 1'b0;
        step();
        chk("ready after second reset", {31'd0, fr10}, 32'd1);
        push_frame(0, 10, 16'h0000, 16'h33DF, 8'h01);
        fv10 = 1'b1;
        step();
        fv10 = 1'b0;
        wait_sent10(200, "post-reset frame sent");
        repeat (3) step();

        chk("u10 queue drained", q10.size(), 32'd0);
        chk("u26 queue drained", q26.size(), 32'd0);
        chk("u27 queue drained", q27.size(), 32'd0);
        chk("u10 FRAME_SENT pulses", cnt_sent10, 32'd5);
        chk("u26 FRAME_SENT pulses", cnt_sent26, 32'd1);
        chk("u27 FRAME_SENT pulses", cnt_sent27, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
